fetch_buffer_stage: RTL

FETCH_BUFFER_STAGE -- requirements
Module: fetch_buffer_stage

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buffer_stage_if.sv | 24 ++
 rtl/fetch_buffer_stage_sync_fifo.sv | 50 +++++
 rtl/fetch_buffer_stage.sv | 108 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: default datapath width, NOP encoding and buffer entry.
// The entry struct is sized by XLEN_DEFAULT, so stages using it run at that width.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [XLEN_DEFAULT-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_stage_if.sv
// Instruction-memory channel: request handshake plus in-order, unthrottled responses.
interface fetch_buffer_stage_if
    import fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

endinterface

// File: rtl/fetch_buffer_stage_sync_fifo.sv
// Synchronous FIFO of arbitrary entry type; power-of-two DEPTH, same-cycle push/pop allowed.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          srst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  T              push_data,
    output T              head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses <= only, so every flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (!srst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is left unreset; pointers and count alone decide which slots hold live data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_buffer_stage.sv
// Instruction fetch with credit-limited memory requests, a decoupling buffer and the IF/ID register.
module fetch_buffer_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 srst_n,
    input  logic                 pcsrc_e,
    input  logic [XLEN-1:0]      pc_target_e,
    input  logic                 stall_d,
    input  logic                 flush_d,
    fetch_buffer_stage_if.master imem,
    output logic                 valid_d,
    output logic [XLEN-1:0]      instr_d,
    output logic [XLEN-1:0]      pc_d,
    output logic [XLEN-1:0]      pc_plus4_d
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   occupancy;
    logic [CW:0]     in_use;
    logic            req_fire;
    logic            rsp_keep;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Every issued request owns a buffer slot until popped, so the buffer can never overflow.
    assign in_use              = {1'b0, occupancy} + {1'b0, outstanding};
    assign imem.imem_req_valid = srst_n && !pcsrc_e && (in_use < (CW + 1)'(DEPTH));
    assign imem.imem_req_addr  = pc_f;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
    assign rsp_keep            = imem.imem_rsp_valid && (drop_cnt == '0) && !pcsrc_e;
    assign pop                 = !pcsrc_e && !flush_d && !stall_d && !fifo_empty;
    assign push_entry          = '{pc: rsp_pc, instr: imem.imem_rsp_data};

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .srst_n    (srst_n),
        .clear     (pcsrc_e),
        .push      (rsp_keep),
        .pop       (pop),
        .push_data (push_entry),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occupancy)
    );

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            pc_f        <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem.imem_rsp_valid);
            if (pcsrc_e) begin
                pc_f     <= pc_target_e;
                rsp_pc   <= pc_target_e;
                // Whatever is still in flight after this edge belongs to the abandoned path.
                drop_cnt <= outstanding - CW'(imem.imem_rsp_valid);
            end else begin
                if (req_fire) pc_f <= pc_f + XLEN'(4);
                if (rsp_keep) rsp_pc <= rsp_pc + XLEN'(4);
                else if (imem.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n || pcsrc_e || flush_d) begin
            valid_d    <= 1'b0;
            instr_d    <= '0;
            pc_d       <= '0;
            pc_plus4_d <= '0;
        end else if (!stall_d) begin
            if (pop) begin
                valid_d    <= 1'b1;
                instr_d    <= head.instr;
                pc_d       <= head.pc;
                pc_plus4_d <= head.pc + XLEN'(4);
            end else begin
                valid_d    <= 1'b0;
                instr_d    <= NOP;
                pc_d       <= '0;
                pc_plus4_d <= '0;
            end
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!srst_n)
        !(rsp_keep && fifo_full && !pop));

endmodule
